// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: baud constants, data width
// and the 2-bit frame FSM encoding.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_12M_115K = 104;
    localparam int unsigned UART_DATA_BITS             = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: tick pulses once every CLKS_PER_BIT cycles after
// restart is released, reloading on every tick so consecutive bits have no gap.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned       CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (restart || (r_count == '0)) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - CW'(1);
        end
    end

    assign tick = (r_count == '0) && !restart;

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-byte holding register so the next byte
// can be queued while the current frame shifts out, giving gapless frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_12M_115K,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_enable,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      tx_ready,
    output logic                      tx,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(UART_DATA_BITS);

    uart_state_t               r_state, w_state_next;
    logic [UART_DATA_BITS-1:0] r_hold;
    logic                      r_hold_full;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
    logic [IW-1:0]             r_bit_idx, w_bit_idx_next;
    logic                      r_stop_idx, w_stop_idx_next;
    logic                      r_tx, w_tx_next;
    logic                      r_busy;
    logic                      w_load;
    logic                      w_tick;
    logic                      w_restart;

    // Counter is held at reload while idle so START always gets a full bit.
    assign w_restart = (r_state == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_idx_next = r_stop_idx;
        w_load          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_state_next = ST_START;
                    w_shift_next = r_hold;
                    w_load       = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == IW'(UART_DATA_BITS - 1)) begin
                        w_state_next    = ST_STOP;
                        w_stop_idx_next = 1'b0;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IW'(1);
                        w_shift_next   = r_shift >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when a byte is queued.
                        if (r_hold_full) begin
                            w_state_next = ST_START;
                            w_shift_next = r_hold;
                            w_load       = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_stop_idx_next = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != ST_IDLE);
            if (w_load) begin
                r_hold_full <= 1'b0;
            end else if (tx_enable && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign tx_ready = ~r_hold_full;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: fast-baud instance (4 clk/bit, 1 stop) and a
// default-baud instance with two stop bits, checked cycle by cycle.
module tb_uart_tx;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, tx_a, rdy_a, busy_a;
    logic [7:0] data_a;
    logic       rst_b, en_b, tx_b, rdy_b, busy_b;
    logic [7:0] data_b;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst_a), .tx_enable(en_a), .tx_data(data_a),
        .tx_ready(rdy_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx #(.STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .tx_enable(en_b), .tx_data(data_b),
        .tx_ready(rdy_b), .tx(tx_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line levels in send order, bit 0 = start bit
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic [7:0] d);
        if (sel == 0) begin en_a = en; data_a = d; end
        else          begin en_b = en; data_b = d; end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    task automatic send_frame(input int sel, input logic [7:0] d, input logic [9:0] frame,
                              input int cpb, input int sb, input string name);
        int   total;
        logic exp;
        total = (9 + sb) * cpb;
        @(negedge clk);
        drive(sel, 1'b1, d);
        @(posedge clk);
        #1 drive(sel, 1'b0, 8'h00);
        @(negedge clk);
        check({name, "/pre_start_tx"}, get_tx(sel), 1'b1);
        check({name, "/ready_after_accept"}, get_rdy(sel), 1'b0);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            exp = (c < 10 * cpb) ? frame[c / cpb] : 1'b1;
            check($sformatf("%s/tx[%0d]", name, c), get_tx(sel), exp);
            if (c == 0) check({name, "/ready_at_start"}, get_rdy(sel), 1'b1);
            if (c == 0 || c == total - 1)
                check($sformatf("%s/busy[%0d]", name, c), get_busy(sel), 1'b1);
        end
        @(negedge clk);
        check({name, "/busy_end"}, get_busy(sel), 1'b0);
        check({name, "/tx_end"}, get_tx(sel), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic       cap[80];
        logic       exp;
        logic       idle_ok;
        logic [9:0] f0, f1, f0f;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};

        // Reset held three edges with tx_enable asserted.
        rst_a = 1'b1; rst_b = 1'b1;
        en_a = 1'b1; en_b = 1'b1; data_a = 8'h12; data_b = 8'h12;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset/tx_a[%0d]", i), tx_a, 1'b1);
            check($sformatf("reset/rdy_a[%0d]", i), rdy_a, 1'b1);
            check($sformatf("reset/busy_a[%0d]", i), busy_a, 1'b0);
            check($sformatf("reset/tx_b[%0d]", i), tx_b, 1'b1);
            check($sformatf("reset/rdy_b[%0d]", i), rdy_b, 1'b1);
            check($sformatf("reset/busy_b[%0d]", i), busy_b, 1'b0);
        end
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("post_reset/tx_a[%0d]", i), tx_a, 1'b1);
            check($sformatf("post_reset/busy_a[%0d]", i), busy_a, 1'b0);
        end

        for (int v = 0; v < 5; v++)
            send_frame(0, vecs[v].data, vecs[v].frame, 4, 1, $sformatf("single_%02h", vecs[v].data));

        // Back-to-back 0x00 then 0xFF, with an overrun 0x3C while the holding register is full.
        f0 = vecs[1].frame;
        f1 = vecs[2].frame;
        @(negedge clk);
        en_a = 1'b1; data_a = 8'h00;
        @(posedge clk);
        #1 en_a = 1'b0;
        @(negedge clk);
        check("b2b/ready_after_first", rdy_a, 1'b0);
        @(negedge clk);
        cap[0] = tx_a;
        check("b2b/ready_at_first_start", rdy_a, 1'b1);
        if (rdy_a && !en_a) begin en_a = 1'b1; data_a = 8'hFF; end
        @(posedge clk);
        #1 en_a = 1'b0;
        @(negedge clk);
        cap[1] = tx_a;
        check("b2b/ready_while_held", rdy_a, 1'b0);
        en_a = 1'b1; data_a = 8'h3C;
        @(posedge clk);
        #1 en_a = 1'b0;
        for (int c = 2; c < 80; c++) begin
            @(negedge clk);
            cap[c] = tx_a;
            if (c == 40) check("b2b/busy_at_second_start", busy_a, 1'b1);
        end
        @(negedge clk);
        check("b2b/busy_end", busy_a, 1'b0);
        for (int c = 0; c < 80; c++) begin
            exp = (c < 40) ? f0[c / 4] : f1[(c - 40) / 4];
            check($sformatf("b2b/tx[%0d]", c), cap[c], exp);
        end
        idle_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_ok = 1'b0;
        end
        check("overrun/line_stays_idle", idle_ok, 1'b1);

        // Reset asserted during data bit 3 of 0x0F.
        f0f = 10'b1000011110;
        @(negedge clk);
        en_a = 1'b1; data_a = 8'h0F;
        @(posedge clk);
        #1 en_a = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            check($sformatf("midrst/tx[%0d]", c), tx_a, f0f[c / 4]);
        end
        rst_a = 1'b1;
        @(negedge clk);
        check("midrst/tx", tx_a, 1'b1);
        check("midrst/ready", rdy_a, 1'b1);
        check("midrst/busy", busy_a, 1'b0);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst/idle_tx[%0d]", i), tx_a, 1'b1);
        end
        send_frame(0, 8'h55, 10'b1010101010, 4, 1, "after_rst_55");

        // Default baud with two stop bits: 1144-cycle frame, 208-cycle stop phase.
        send_frame(1, 8'h80, 10'b1100000000, UART_CLKS_PER_BIT_12M_115K, 2, "b_80");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
